// File: rtl/rast_sample_iter.sv
`default_nettype none
// ============================================================================
//  Module      : rast_sample_iter
//  Description : Sample iterator between the bbox and sample-test stages.
//                Accepts one triangle with its inclusive screen bbox and walks
//                the sample grid inside the box, one sample per cycle, in
//                raster or serpentine order at 1/4/16/64 samples per pixel.
//  Ports       : clk, rst_n         clock, async active-low reset
//                tri_i, color_i     triangle vertices / colour (latched)
//                box_i              {ur_y,ur_x,ll_y,ll_x} inclusive bbox
//                subsample_i        one-hot 1000=1x,0100=4x,0010=16x,0001=64x
//                serp_i             serpentine row order when 1
//                valid_i / ready_o  triangle handshake
//                tri_o, color_o     triangle/colour travelling with samples
//                sample_o           {y,x} sample position
//                valid_o / ready_i  sample handshake, last_o marks final one
//  Revision    : 1.0  initial release
// ============================================================================
module rast_sample_iter #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [VERTS*AXIS*SIGFIG-1:0]    tri_i,
   input  logic [COLORS*SIGFIG-1:0]        color_i,
   input  logic [4*SIGFIG-1:0]             box_i,
   input  logic [3:0]                      subsample_i,
   input  logic                            serp_i,
   input  logic                            valid_i,
   output logic                            ready_o,
   output logic [VERTS*AXIS*SIGFIG-1:0]    tri_o,
   output logic [COLORS*SIGFIG-1:0]        color_o,
   output logic [2*SIGFIG-1:0]             sample_o,
   output logic                            valid_o,
   output logic                            last_o,
   input  logic                            ready_i
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_iter  = 2'd1;
   localparam logic [1:0] c_st_empty = 2'd2;

   localparam logic [SIGFIG-1:0] c_one     = {{(SIGFIG-1){1'b0}}, 1'b1};
   localparam logic [SIGFIG-1:0] c_step_1x = c_one << RADIX;
   localparam logic [SIGFIG-1:0] c_step_4x = c_one << (RADIX-1);
   localparam logic [SIGFIG-1:0] c_step_16x = c_one << (RADIX-2);
   localparam logic [SIGFIG-1:0] c_step_64x = c_one << (RADIX-3);

   // ---------------------------------------------------------------- state
   logic [1:0]                       r_state;
   logic [VERTS*AXIS*SIGFIG-1:0]     r_tri;
   logic [COLORS*SIGFIG-1:0]         r_color;
   logic [SIGFIG-1:0]                r_llx;
   logic [SIGFIG-1:0]                r_urx;
   logic [SIGFIG-1:0]                r_ury;
   logic [SIGFIG-1:0]                r_xr;     // rightmost grid point <= ur_x
   logic [SIGFIG-1:0]                r_step;
   logic                             r_serp;
   logic                             r_dir;    // 1 = walking right-to-left
   logic [SIGFIG-1:0]                r_x;
   logic [SIGFIG-1:0]                r_y;

   logic                             r_valid;
   logic                             r_last;
   logic [2*SIGFIG-1:0]              r_sample;
   logic [VERTS*AXIS*SIGFIG-1:0]     r_tri_o;
   logic [COLORS*SIGFIG-1:0]         r_color_o;

   // -------------------------------------------------------- accept decode
   logic [SIGFIG-1:0]                w_in_llx;
   logic [SIGFIG-1:0]                w_in_lly;
   logic [SIGFIG-1:0]                w_in_urx;
   logic [SIGFIG-1:0]                w_in_ury;
   logic [SIGFIG-1:0]                w_step;
   logic [SIGFIG-1:0]                w_mask;
   logic                             w_empty;

   assign w_in_llx = box_i[0*SIGFIG +: SIGFIG];
   assign w_in_lly = box_i[1*SIGFIG +: SIGFIG];
   assign w_in_urx = box_i[2*SIGFIG +: SIGFIG];
   assign w_in_ury = box_i[3*SIGFIG +: SIGFIG];

   always_comb begin
      w_step = c_step_1x;   // anything that is not one-hot falls back to 1x
      case (subsample_i)
         4'b0100: w_step = c_step_4x;
         4'b0010: w_step = c_step_16x;
         4'b0001: w_step = c_step_64x;
         default: w_step = c_step_1x;
      endcase
   end

   // Step is a power of two, so snapping is a mask. The grid is absolute,
   // which also makes ur & mask the rightmost grid point of every row.
   assign w_mask  = ~(w_step - c_one);
   assign w_empty = ($signed(w_in_urx) < $signed(w_in_llx)) ||
                    ($signed(w_in_ury) < $signed(w_in_lly));

   // ----------------------------------------------------- iteration decode
   logic [SIGFIG:0]                  w_x_plus;
   logic [SIGFIG:0]                  w_y_plus;
   logic                             w_row_end;
   logic                             w_last_row;
   logic                             w_last;
   logic                             w_adv;
   logic [SIGFIG-1:0]                w_x_next;
   logic                             w_dir_next;

   // One extra bit so a box at positive full scale cannot wrap.
   assign w_x_plus = {r_x[SIGFIG-1], r_x} + {1'b0, r_step};
   assign w_y_plus = {r_y[SIGFIG-1], r_y} + {1'b0, r_step};

   assign w_row_end  = r_dir ? (r_x == r_llx)
                             : ($signed(w_x_plus) > $signed({r_urx[SIGFIG-1], r_urx}));
   assign w_last_row = $signed(w_y_plus) > $signed({r_ury[SIGFIG-1], r_ury});
   assign w_last     = w_row_end && w_last_row;
   assign w_adv      = (r_state == c_st_iter) && (!r_valid || ready_i);

   always_comb begin
      w_x_next   = r_x;
      w_dir_next = r_dir;
      if (!w_row_end) begin
         w_x_next = r_dir ? (r_x - r_step) : w_x_plus[SIGFIG-1:0];
      end else if (r_serp && !r_dir) begin
         w_x_next   = r_xr;
         w_dir_next = 1'b1;
      end else begin
         w_x_next   = r_llx;
         w_dir_next = 1'b0;
      end
   end

   // -------------------------------------------------------------- control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
         r_tri   <= '0;
         r_color <= '0;
         r_llx   <= '0;
         r_urx   <= '0;
         r_ury   <= '0;
         r_xr    <= '0;
         r_step  <= '0;
         r_serp  <= 1'b0;
         r_dir   <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (valid_i) begin
                  r_tri   <= tri_i;
                  r_color <= color_i;
                  r_llx   <= w_in_llx & w_mask;
                  r_urx   <= w_in_urx;
                  r_ury   <= w_in_ury;
                  r_xr    <= w_in_urx & w_mask;
                  r_step  <= w_step;
                  r_serp  <= serp_i;
                  r_dir   <= 1'b0;
                  r_x     <= w_in_llx & w_mask;
                  r_y     <= w_in_lly & w_mask;
                  r_state <= w_empty ? c_st_empty : c_st_iter;
               end
            end
            c_st_iter: begin
               if (w_adv) begin
                  if (w_last) begin
                     r_state <= c_st_idle;
                  end else begin
                     r_x   <= w_x_next;
                     r_dir <= w_dir_next;
                     if (w_row_end) begin
                        r_y <= w_y_plus[SIGFIG-1:0];
                     end
                  end
               end
            end
            c_st_empty: r_state <= c_st_idle;
            default:    r_state <= c_st_idle;
         endcase
      end
   end

   // -------------------------------------------------------- output register
   // The triangle and colour travel with the sample so a new triangle can be
   // accepted while the previous last sample is still stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_sample  <= '0;
         r_tri_o   <= '0;
         r_color_o <= '0;
      end else if (w_adv) begin
         r_valid   <= 1'b1;
         r_last    <= w_last;
         r_sample  <= {r_y, r_x};
         r_tri_o   <= r_tri;
         r_color_o <= r_color;
      end else if (ready_i) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
   end

   assign ready_o  = (r_state == c_st_idle);
   assign valid_o  = r_valid;
   assign last_o   = r_last;
   assign sample_o = r_sample;
   assign tri_o    = r_tri_o;
   assign color_o  = r_color_o;

endmodule
`default_nettype wire
